// File: rtl/timer_rega_dec.sv
// Two-digit BCD watering-cycle countdown timer. Counts minutes made of PRESCALE
// Tick strobes and keeps the valve open only while a run is active.
//
// state | meaning
// IDLE  | preset held, valve closed, waiting for Start
// RUN   | valve open, prescaler advancing on Tick, count decrementing per minute
// PAUSE | valve closed, prescaler and count frozen until Start or Stop
// DONE  | countdown reached 00, valve closed, waiting for Stop or Load
module timer_rega_dec #(
  parameter int PRESCALE   = 60,
  parameter int PRESCALE_W = 6
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Tick,
  input  logic       Load,
  input  logic [3:0] Dez_in,
  input  logic [3:0] Uni_in,
  input  logic       Start,
  input  logic       Stop,
  output logic [3:0] Dez,
  output logic [3:0] Uni,
  output logic       Valvula,
  output logic       Fim,
  output logic [1:0] Estado
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(PRESCALE - 1);
  localparam logic [PRESCALE_W-1:0] PRESC_ZERO = '0;
  localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);

  logic [1:0]            r_state;
  logic [3:0]            r_dez;
  logic [3:0]            r_uni;
  logic [PRESCALE_W-1:0] r_presc;
  logic                  r_valv;
  logic                  r_zero_hit;
  logic                  r_fim;

  logic [1:0]            w_state_nx;
  logic [3:0]            w_dez_nx;
  logic [3:0]            w_uni_nx;
  logic [PRESCALE_W-1:0] w_presc_nx;
  logic                  w_zero_hit_nx;

  logic [3:0]            w_dez_clamp;
  logic [3:0]            w_uni_clamp;
  logic                  w_count_zero;
  logic [3:0]            w_dec_dez;
  logic [3:0]            w_dec_uni;
  logic                  w_dec_zero;
  logic                  w_minute_end;

  assign w_dez_clamp  = (Dez_in > 4'd9) ? 4'd9 : Dez_in;
  assign w_uni_clamp  = (Uni_in > 4'd9) ? 4'd9 : Uni_in;
  assign w_count_zero = (r_dez == 4'd0) && (r_uni == 4'd0);

  // BCD borrow: units wrap 0 -> 9 and take one from the tens digit.
  assign w_dec_uni    = (r_uni == 4'd0) ? 4'd9 : (r_uni - 4'd1);
  assign w_dec_dez    = (r_uni == 4'd0) ? (r_dez - 4'd1) : r_dez;
  assign w_dec_zero   = (w_dec_dez == 4'd0) && (w_dec_uni == 4'd0);
  assign w_minute_end = (r_presc == PRESC_LAST);

  always_comb begin
    w_state_nx    = r_state;
    w_dez_nx      = r_dez;
    w_uni_nx      = r_uni;
    w_presc_nx    = r_presc;
    w_zero_hit_nx = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (Load) begin
          w_dez_nx   = w_dez_clamp;
          w_uni_nx   = w_uni_clamp;
          w_presc_nx = PRESC_ZERO;
        end else if (Start && !w_count_zero) begin
          w_state_nx = ST_RUN;
          w_presc_nx = PRESC_ZERO;
        end
      end

      ST_RUN: begin
        // Stop wins over a coincident Tick; that Tick is simply lost.
        if (Stop) begin
          w_state_nx = ST_PAUSE;
        end else if (Tick) begin
          if (w_minute_end) begin
            w_presc_nx = PRESC_ZERO;
            w_dez_nx   = w_dec_dez;
            w_uni_nx   = w_dec_uni;
            if (w_dec_zero) begin
              w_state_nx    = ST_DONE;
              w_zero_hit_nx = 1'b1;
            end
          end else begin
            w_presc_nx = r_presc + PRESC_ONE;
          end
        end
      end

      ST_PAUSE: begin
        if (Load) begin
          w_state_nx = ST_IDLE;
          w_dez_nx   = w_dez_clamp;
          w_uni_nx   = w_uni_clamp;
          w_presc_nx = PRESC_ZERO;
        end else if (Stop) begin
          w_state_nx = ST_IDLE;
          w_dez_nx   = 4'd0;
          w_uni_nx   = 4'd0;
          w_presc_nx = PRESC_ZERO;
        end else if (Start) begin
          w_state_nx = ST_RUN;
        end
      end

      ST_DONE: begin
        if (Load) begin
          w_state_nx = ST_IDLE;
          w_dez_nx   = w_dez_clamp;
          w_uni_nx   = w_uni_clamp;
          w_presc_nx = PRESC_ZERO;
        end else if (Stop) begin
          w_state_nx = ST_IDLE;
        end
      end

      default: begin
        w_state_nx = ST_IDLE;
        w_dez_nx   = 4'd0;
        w_uni_nx   = 4'd0;
        w_presc_nx = PRESC_ZERO;
      end
    endcase
  end

  // Fim trails the edge that enters DONE by one cycle, so it is seen after
  // the valve has already closed.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= ST_IDLE;
      r_dez      <= 4'd0;
      r_uni      <= 4'd0;
      r_presc    <= PRESC_ZERO;
      r_valv     <= 1'b0;
      r_zero_hit <= 1'b0;
      r_fim      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_dez      <= w_dez_nx;
      r_uni      <= w_uni_nx;
      r_presc    <= w_presc_nx;
      r_valv     <= (w_state_nx == ST_RUN);
      r_zero_hit <= w_zero_hit_nx;
      r_fim      <= r_zero_hit;
    end
  end

  assign Dez     = r_dez;
  assign Uni     = r_uni;
  assign Valvula = r_valv;
  assign Fim     = r_fim;
  assign Estado  = r_state;

endmodule

// File: tb/tb_timer_rega_dec.sv
// Directed bench for timer_rega_dec with PRESCALE=3: a cycle-by-cycle vector
// table plus a hand-written asynchronous mid-run reset sequence.
module tb_timer_rega_dec;

  logic       Clk;
  logic       Rst_n;
  logic       Tick;
  logic       Load;
  logic [3:0] Dez_in;
  logic [3:0] Uni_in;
  logic       Start;
  logic       Stop;
  logic [3:0] Dez;
  logic [3:0] Uni;
  logic       Valvula;
  logic       Fim;
  logic [1:0] Estado;

  int n_checks = 0;
  int n_fail   = 0;

  timer_rega_dec #(.PRESCALE(3), .PRESCALE_W(6)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Tick    (Tick),
    .Load    (Load),
    .Dez_in  (Dez_in),
    .Uni_in  (Uni_in),
    .Start   (Start),
    .Stop    (Stop),
    .Dez     (Dez),
    .Uni     (Uni),
    .Valvula (Valvula),
    .Fim     (Fim),
    .Estado  (Estado)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       ld;
    logic [3:0] di;
    logic [3:0] ui;
    logic       st;
    logic       sp;
    logic       tk;
    logic [3:0] ed;
    logic [3:0] eu;
    logic [1:0] es;
    logic       ev;
    logic       ef;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic ld, input logic [3:0] di, input logic [3:0] ui,
                              input logic st, input logic sp, input logic tk,
                              input logic [3:0] ed, input logic [3:0] eu, input logic [1:0] es,
                              input logic ev, input logic ef);
    vec_t v;
    v.ld = ld; v.di = di; v.ui = ui; v.st = st; v.sp = sp; v.tk = tk;
    v.ed = ed; v.eu = eu; v.es = es; v.ev = ev; v.ef = ef;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ed, input logic [3:0] eu,
                         input logic [1:0] es, input logic ev, input logic ef);
    chk({tag, "_dez"},  {4'd0, Dez},     {4'd0, ed});
    chk({tag, "_uni"},  {4'd0, Uni},     {4'd0, eu});
    chk({tag, "_st"},   {6'd0, Estado},  {6'd0, es});
    chk({tag, "_valv"}, {7'd0, Valvula}, {7'd0, ev});
    chk({tag, "_fim"},  {7'd0, Fim},     {7'd0, ef});
  endtask

  task automatic drive(input logic ld, input logic [3:0] di, input logic [3:0] ui,
                       input logic st, input logic sp, input logic tk);
    Load = ld; Dez_in = di; Uni_in = ui; Start = st; Stop = sp; Tick = tk;
  endtask

  initial begin
    // ld di ui st sp tk | dez uni st valv fim
    add(0, 0, 0, 1, 0, 0,   0, 0, 2'd0, 0, 0);  // Start with 00 ignored
    add(1, 1, 0, 0, 0, 0,   1, 0, 2'd0, 0, 0);
    add(0, 0, 0, 1, 0, 0,   1, 0, 2'd1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   1, 0, 2'd1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   1, 0, 2'd1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   0, 9, 2'd1, 1, 0);  // borrow 10 -> 09
    add(1, 0, 5, 0, 0, 0,   0, 9, 2'd1, 1, 0);  // Load in RUN ignored
    add(0, 0, 0, 0, 0, 1,   0, 9, 2'd1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   0, 9, 2'd1, 1, 0);  // prescaler now 2
    add(0, 0, 0, 0, 1, 1,   0, 9, 2'd2, 0, 0);  // Stop beats Tick
    add(0, 0, 0, 0, 0, 1,   0, 9, 2'd2, 0, 0);
    add(0, 0, 0, 1, 0, 0,   0, 9, 2'd1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   0, 8, 2'd1, 1, 0);  // held prescaler 2 wraps
    add(0, 0, 0, 1, 1, 0,   0, 8, 2'd2, 0, 0);  // Stop beats Start
    add(0, 0, 0, 0, 1, 0,   0, 0, 2'd0, 0, 0);  // abort clears count
    add(1, 12, 15, 0, 0, 0, 9, 9, 2'd0, 0, 0);  // clamp
    add(1, 0, 1, 0, 0, 0,   0, 1, 2'd0, 0, 0);
    add(0, 0, 0, 1, 0, 0,   0, 1, 2'd1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 2'd1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 2'd1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   0, 0, 2'd3, 0, 0);  // reach 00 -> DONE
    add(0, 0, 0, 1, 0, 0,   0, 0, 2'd3, 0, 1);  // Fim pulse, Start ignored
    add(0, 0, 0, 0, 0, 0,   0, 0, 2'd3, 0, 0);
    add(1, 0, 2, 0, 0, 0,   0, 2, 2'd0, 0, 0);  // Load from DONE
    add(0, 0, 0, 1, 0, 0,   0, 2, 2'd1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   0, 2, 2'd1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   0, 2, 2'd1, 1, 0);
    add(0, 0, 0, 0, 1, 0,   0, 2, 2'd2, 0, 0);
    for (int k = 0; k < 5; k++)
      add(0, 0, 0, 0, 0, 1, 0, 2, 2'd2, 0, 0);  // Ticks ignored in PAUSE
    add(0, 0, 0, 1, 0, 0,   0, 2, 2'd1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 2'd1, 1, 0);  // resume at prescaler 2
    add(0, 0, 0, 0, 1, 0,   0, 1, 2'd2, 0, 0);
    add(1, 0, 3, 1, 0, 0,   0, 3, 2'd0, 0, 0);  // Load beats Start in PAUSE
    add(0, 0, 0, 1, 0, 0,   0, 3, 2'd1, 1, 0);
    add(0, 0, 0, 0, 1, 0,   0, 3, 2'd2, 0, 0);
    add(0, 0, 0, 0, 1, 0,   0, 0, 2'd0, 0, 0);  // abort, no Fim
    add(0, 0, 0, 0, 0, 0,   0, 0, 2'd0, 0, 0);
    add(1, 0, 1, 0, 0, 0,   0, 1, 2'd0, 0, 0);
    add(0, 0, 0, 1, 0, 0,   0, 1, 2'd1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 2'd1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 2'd1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   0, 0, 2'd3, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 2'd3, 0, 1);
    add(0, 0, 0, 0, 1, 0,   0, 0, 2'd0, 0, 0);  // Stop in DONE

    Rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk_all("reset", 0, 0, 2'd0, 0, 0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Mid-run asynchronous reset
    drive(1, 1, 2, 0, 0, 0);
    @(negedge Clk);
    drive(0, 0, 0, 1, 0, 0);
    @(negedge Clk);
    drive(0, 0, 0, 0, 0, 1);
    @(negedge Clk);
    @(negedge Clk);
    drive(0, 0, 0, 0, 0, 0);
    chk_all("prerst", 1, 2, 2'd1, 1, 0);
    #2 Rst_n = 1'b0;
    #1;
    chk_all("asyncrst", 0, 0, 2'd0, 0, 0);
    @(negedge Clk);
    chk({"asyncrst_fim2"}, {7'd0, Fim}, 8'd0);
    Rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].ld, vq[i].di, vq[i].ui, vq[i].st, vq[i].sp, vq[i].tk);
      @(negedge Clk);
      chk_all($sformatf("v%0d", i), vq[i].ed, vq[i].eu, vq[i].es, vq[i].ev, vq[i].ef);
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
